pipeline_hold_ctrl: RTL

Central pipeline-control sequencer for the cached five-stage core. Consumes the load-use stall request from hazard detection, the taken-branch signal from Execute, and the data-cache hit/miss status from Memory. Drives per-stage register enables and flushes. Owns the refill request/acknowledge handshake with the cache refill engine, so a multi-cycle miss freezes the whole pipeline and replays the Memory-stage access.

---
 rtl/pipeline_hold_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hold_ctrl.sv
// Pipeline hold/flush sequencer: load-use stall, branch flush and data-cache miss freeze with refill handshake.
// Optional stall performance counter is enabled by defining STALL_PERF_CNT_EN.
module pipeline_hold_ctrl #(
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             LoadUseD,
   input  logic             PCSrcE,
   input  logic             MemAccessM,
   input  logic             CacheHitM,
   input  logic             RefillAck,
   output logic             EnF,
   output logic             EnD,
   output logic             EnE,
   output logic             EnM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             RefillReq,
   output logic             RefillTimeout,
   output logic [CNT_W-1:0] StallCycles
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_wait;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic [WAIT_W-1:0]   w_wait_inc;
   logic                r_refill_req;
   logic                r_timeout;
   logic                w_timeout_set;
   logic                w_miss;
   logic [3:0]          w_en;     // {F, D, E, M}
   logic [2:0]          w_flush;  // {D, E, W}

   assign w_miss     = MemAccessM & ~CacheHitM;
   assign w_wait_inc = (r_wait == WAIT_MAX) ? r_wait : (r_wait + WAIT_ONE);

   // Next-state, wait-counter and stage-control decode
   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait;
      w_timeout_set = 1'b0;
      w_en          = 4'b1111;
      w_flush       = 3'b000;
      case (r_state)
         ST_RUN: begin
            if (w_miss) begin
               w_en        = 4'b0000;
               w_flush     = 3'b001;
               w_state_nxt = ST_REQ;
               w_wait_nxt  = {WAIT_W{1'b0}};
            end else if (PCSrcE) begin
               w_en    = 4'b1111;
               w_flush = 3'b110;
            end else if (LoadUseD) begin
               w_en    = 4'b0011;
               w_flush = 3'b010;
            end else begin
               w_en    = 4'b1111;
               w_flush = 3'b000;
            end
         end
         ST_REQ: begin
            w_en       = 4'b0000;
            w_flush    = 3'b001;
            w_wait_nxt = w_wait_inc;
            // Ack wins over a timeout landing in the same cycle
            if (RefillAck) begin
               w_state_nxt = ST_DONE;
            end else if (r_wait >= WAIT_LAST) begin
               w_timeout_set = 1'b1;
               w_state_nxt   = ST_DONE;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_DONE: begin
            w_en        = 4'b0000;
            w_flush     = 3'b001;
            w_wait_nxt  = {WAIT_W{1'b0}};
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_en        = 4'b0000;
            w_flush     = 3'b001;
            w_wait_nxt  = {WAIT_W{1'b0}};
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Sequencer state, wait counter, refill request and sticky timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_wait       <= {WAIT_W{1'b0}};
         r_refill_req <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wait       <= w_wait_nxt;
         r_refill_req <= (w_state_nxt == ST_REQ);
         r_timeout    <= r_timeout | w_timeout_set;
      end
   end

   // Reset overrides the decode so every stage register holds and clears while rst_n is low
   assign EnF    = w_en[3] & rst_n;
   assign EnD    = w_en[2] & rst_n;
   assign EnE    = w_en[1] & rst_n;
   assign EnM    = w_en[0] & rst_n;
   assign FlushD = w_flush[2] | ~rst_n;
   assign FlushE = w_flush[1] | ~rst_n;
   assign FlushW = w_flush[0] | ~rst_n;

   assign RefillReq     = r_refill_req;
   assign RefillTimeout = r_timeout;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating count of cycles with fetch held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= {CNT_W{1'b0}};
      end else if (!EnF && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign StallCycles = r_stall_cnt;
`else
   assign StallCycles = {CNT_W{1'b0}};
`endif

endmodule
